// File: rtl/lift_call_scheduler.sv
// SCAN hall/car-call scheduler: latches floor calls, picks the next target in the
// current travel direction, drives the direction/target handshake and times the door dwell.
module lift_call_scheduler #(
   parameter int FLOORS = 8,
   parameter int FW     = 3,
   parameter int DWELL  = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [FLOORS-1:0] call_req,
   input  logic [FW-1:0]     cur_floor,
   input  logic              arrive,
   input  logic              door_hold,
   output logic [FLOORS-1:0] pending,
   output logic [FW-1:0]     target_floor,
   output logic              target_valid,
   output logic              dir_up,
   output logic              dir_dn,
   output logic              door_open
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_SEEK_UP = 2'd1,
      ST_SEEK_DN = 2'd2,
      ST_DWELL   = 2'd3
   } state_t;

   localparam logic [7:0] DWELL_LOAD = 8'(DWELL - 1);

   state_t            state_r;
   state_t            state_nxt_s;
   logic              last_up_r;
   logic              last_up_nxt_s;
   logic [7:0]        dwell_cnt_r;
   logic [7:0]        dwell_nxt_s;
   logic [FLOORS-1:0] floor_hot_s;
   logic [FLOORS-1:0] above_raw_s;
   logic [FLOORS-1:0] below_raw_s;
   logic [FLOORS-1:0] above_s;
   logic [FLOORS-1:0] below_s;
   logic [FLOORS-1:0] clr_s;
   logic [FLOORS-1:0] mask_s;
   logic [FLOORS-1:0] pending_nxt_s;
   logic [FW-1:0]     target_nxt_s;
   logic              floor_ok_s;
   logic              here_s;
   logic              call_here_s;
   logic              reload_s;

   function automatic logic [FW-1:0] lowest_set(input logic [FLOORS-1:0] v);
      logic [FW-1:0] idx;
      idx = {FW{1'b0}};
      for (int i = FLOORS - 1; i >= 0; i--) begin
         idx = v[i] ? FW'(i) : idx;
      end
      return idx;
   endfunction

   function automatic logic [FW-1:0] highest_set(input logic [FLOORS-1:0] v);
      logic [FW-1:0] idx;
      idx = {FW{1'b0}};
      for (int i = 0; i < FLOORS; i++) begin
         idx = v[i] ? FW'(i) : idx;
      end
      return idx;
   endfunction

   // Split pending calls into above/here/below relative to the car; an out-of-range floor sees nothing.
   always_comb begin
      floor_hot_s = {FLOORS{1'b0}};
      above_raw_s = {FLOORS{1'b0}};
      below_raw_s = {FLOORS{1'b0}};
      for (int i = 0; i < FLOORS; i++) begin
         if (cur_floor == FW'(i)) begin
            floor_hot_s[i] = 1'b1;
         end else if (cur_floor < FW'(i)) begin
            above_raw_s[i] = pending[i];
         end else begin
            below_raw_s[i] = pending[i];
         end
      end
      floor_ok_s  = |floor_hot_s;
      above_s     = above_raw_s & {FLOORS{floor_ok_s}};
      below_s     = below_raw_s & {FLOORS{floor_ok_s}};
      here_s      = |(pending & floor_hot_s);
      call_here_s = |(call_req & floor_hot_s);
      reload_s    = door_hold | call_here_s;
   end

   // Next state, dwell timer, direction memory and pending-call update.
   always_comb begin
      state_nxt_s   = state_r;
      last_up_nxt_s = last_up_r;
      dwell_nxt_s   = dwell_cnt_r;
      clr_s         = {FLOORS{1'b0}};
      mask_s        = {FLOORS{1'b0}};
      case (state_r)
         ST_IDLE: begin
            if (here_s) begin
               state_nxt_s = ST_DWELL;
            end else if (|above_s) begin
               state_nxt_s = ST_SEEK_UP;
            end else if (|below_s) begin
               state_nxt_s = ST_SEEK_DN;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_SEEK_UP: begin
            last_up_nxt_s = 1'b1;
            if (arrive && (cur_floor == target_floor)) begin
               state_nxt_s = ST_DWELL;
            end else if (~|above_s) begin
               state_nxt_s = (|below_s) ? ST_SEEK_DN : ST_IDLE;
            end else begin
               state_nxt_s = ST_SEEK_UP;
            end
         end
         ST_SEEK_DN: begin
            last_up_nxt_s = 1'b0;
            if (arrive && (cur_floor == target_floor)) begin
               state_nxt_s = ST_DWELL;
            end else if (~|below_s) begin
               state_nxt_s = (|above_s) ? ST_SEEK_UP : ST_IDLE;
            end else begin
               state_nxt_s = ST_SEEK_DN;
            end
         end
         ST_DWELL: begin
            // A press at the open door extends the stop rather than queueing a new call.
            mask_s = floor_hot_s;
            if (reload_s) begin
               dwell_nxt_s = DWELL_LOAD;
            end else if (dwell_cnt_r != 8'd0) begin
               dwell_nxt_s = dwell_cnt_r - 8'd1;
            end else if (last_up_r && (|above_s)) begin
               state_nxt_s = ST_SEEK_UP;
            end else if (!last_up_r && (|below_s)) begin
               state_nxt_s = ST_SEEK_DN;
            end else if (|above_s) begin
               state_nxt_s = ST_SEEK_UP;
            end else if (|below_s) begin
               state_nxt_s = ST_SEEK_DN;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         default: begin
            state_nxt_s = ST_IDLE;
         end
      endcase

      if ((state_nxt_s == ST_DWELL) && (state_r != ST_DWELL)) begin
         dwell_nxt_s = DWELL_LOAD;
         clr_s       = floor_hot_s;
      end else begin
         clr_s       = {FLOORS{1'b0}};
      end

      pending_nxt_s = (pending | (call_req & ~mask_s)) & ~clr_s;

      case (state_nxt_s)
         ST_SEEK_UP: target_nxt_s = lowest_set(above_s);
         ST_SEEK_DN: target_nxt_s = highest_set(below_s);
         default:    target_nxt_s = {FW{1'b0}};
      endcase
   end

   // State and registered outputs; outputs reflect the state being entered.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r      <= ST_IDLE;
         last_up_r    <= 1'b1;
         dwell_cnt_r  <= 8'd0;
         pending      <= {FLOORS{1'b0}};
         target_floor <= {FW{1'b0}};
         target_valid <= 1'b0;
         dir_up       <= 1'b0;
         dir_dn       <= 1'b0;
         door_open    <= 1'b0;
      end else begin
         state_r      <= state_nxt_s;
         last_up_r    <= last_up_nxt_s;
         dwell_cnt_r  <= dwell_nxt_s;
         pending      <= pending_nxt_s;
         target_floor <= target_nxt_s;
         target_valid <= (state_nxt_s == ST_SEEK_UP) || (state_nxt_s == ST_SEEK_DN);
         dir_up       <= (state_nxt_s == ST_SEEK_UP);
         dir_dn       <= (state_nxt_s == ST_SEEK_DN);
         door_open    <= (state_nxt_s == ST_DWELL);
      end
   end

endmodule

// File: tb/tb_lift_call_scheduler.sv
// Self-checking bench for lift_call_scheduler: directed scenarios plus a randomized
// car, all compared cycle by cycle against a behavioural SCAN model.
module tb_lift_call_scheduler;
   localparam int FLOORS = 8;
   localparam int FW     = 3;
   localparam int DWELL  = 4;

   logic              clk = 1'b0;
   logic              rst;
   logic [FLOORS-1:0] call_req;
   logic [FW-1:0]     cur_floor;
   logic              arrive;
   logic              door_hold;
   logic [FLOORS-1:0] pending;
   logic [FW-1:0]     target_floor;
   logic              target_valid;
   logic              dir_up;
   logic              dir_dn;
   logic              door_open;

   int total = 0;
   int bad   = 0;

   // model: mode 0=idle 1=going up 2=going down 3=door open; rem = door cycles still to run
   int              m_mode;
   bit [FLOORS-1:0] m_pend;
   int              m_rem;
   bit              m_up;
   int              e_tgt;
   bit              e_valid, e_up, e_dn, e_door;

   always #5 clk = ~clk;

   lift_call_scheduler #(.FLOORS(FLOORS), .FW(FW), .DWELL(DWELL)) dut (
      .clk(clk), .rst(rst), .call_req(call_req), .cur_floor(cur_floor),
      .arrive(arrive), .door_hold(door_hold), .pending(pending),
      .target_floor(target_floor), .target_valid(target_valid),
      .dir_up(dir_up), .dir_dn(dir_dn), .door_open(door_open)
   );

   task automatic check(input string tag, input int obs, input int exp);
      total++;
      if (obs != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_mode = 0; m_pend = '0; m_rem = 0; m_up = 1'b1;
      e_tgt = 0; e_valid = 0; e_up = 0; e_dn = 0; e_door = 0;
   endtask

   function automatic int lowest_above(int cf);
      for (int p = cf + 1; p < FLOORS; p++) if (m_pend[p]) return p;
      return -1;
   endfunction

   function automatic int highest_below(int cf);
      for (int p = cf - 1; p >= 0; p--) if (m_pend[p]) return p;
      return -1;
   endfunction

   task automatic model_step();
      int cf, la, hb, nm;
      bit ok, here;
      cf   = int'(cur_floor);
      ok   = cf < FLOORS;
      la   = ok ? lowest_above(cf) : -1;
      hb   = ok ? highest_below(cf) : -1;
      here = ok && m_pend[cf];
      nm   = m_mode;
      case (m_mode)
         0: begin
            if (here) nm = 3;
            else if (la >= 0) nm = 1;
            else if (hb >= 0) nm = 2;
         end
         1: begin
            m_up = 1'b1;
            if (arrive && cf == e_tgt) nm = 3;
            else if (la < 0) nm = (hb >= 0) ? 2 : 0;
         end
         2: begin
            m_up = 1'b0;
            if (arrive && cf == e_tgt) nm = 3;
            else if (hb < 0) nm = (la >= 0) ? 1 : 0;
         end
         default: begin
            if (door_hold || (ok && call_req[cf])) m_rem = DWELL;
            else begin
               m_rem--;
               if (m_rem == 0) begin
                  if (m_up && la >= 0) nm = 1;
                  else if (!m_up && hb >= 0) nm = 2;
                  else if (la >= 0) nm = 1;
                  else if (hb >= 0) nm = 2;
                  else nm = 0;
               end
            end
         end
      endcase
      for (int p = 0; p < FLOORS; p++)
         if (call_req[p] && !(m_mode == 3 && p == cf)) m_pend[p] = 1'b1;
      if (nm == 3 && m_mode != 3) begin
         m_rem = DWELL;
         m_pend[cf] = 1'b0;
      end
      e_tgt   = (nm == 1) ? la : (nm == 2) ? hb : 0;
      e_valid = (nm == 1) || (nm == 2);
      e_up    = (nm == 1);
      e_dn    = (nm == 2);
      e_door  = (nm == 3);
      m_mode  = nm;
   endtask

   task automatic compare_all();
      check("pending",      int'(pending),      int'(m_pend));
      check("target_floor", int'(target_floor), e_tgt);
      check("target_valid", int'(target_valid), int'(e_valid));
      check("dir_up",       int'(dir_up),       int'(e_up));
      check("dir_dn",       int'(dir_dn),       int'(e_dn));
      check("door_open",    int'(door_open),    int'(e_door));
   endtask

   task automatic cycle();
      @(posedge clk);
      if (rst) model_reset();
      else model_step();
      #1;
      compare_all();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      call_req = '0; arrive = 1'b0; door_hold = 1'b0;
      model_reset();
      cycle();
      cycle();
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic run_cycles(input int n);
      for (int k = 0; k < n; k++) cycle();
   endtask

   initial begin
      rst = 1'b1; call_req = '0; cur_floor = '0; arrive = 1'b0; door_hold = 1'b0;
      model_reset();
      #1;
      check("reset_outputs", int'({pending, target_floor, target_valid, dir_up, dir_dn, door_open}), 0);
      do_reset();

      // basic trip to floor 5 with an ignored arrival on the way
      cur_floor = 3'd0; call_req = 8'h20;
      cycle();
      check("s1_pending_latched", int'(pending), 32'h20);
      call_req = '0;
      cycle();
      check("s1_dir_up", int'(dir_up), 1);
      check("s1_target", int'(target_floor), 5);
      cur_floor = 3'd3; arrive = 1'b1;
      cycle();
      check("ignored_arrive_target", int'(target_floor), 5);
      check("ignored_arrive_pending", int'(pending), 32'h20);
      cur_floor = 3'd5;
      cycle();
      arrive = 1'b0;
      check("s1_door_open", int'(door_open), 1);
      check("s1_pending_cleared", int'(pending), 0);
      for (int k = 0; k < 3; k++) begin
         cycle();
         check("s1_door_held", int'(door_open), 1);
      end
      cycle();
      check("s1_idle", int'({target_valid, dir_up, dir_dn, door_open}), 0);

      // re-target to a nearer call, then continue upward
      cur_floor = 3'd1; call_req = 8'h40;
      cycle();
      call_req = '0;
      cycle();
      cur_floor = 3'd2; call_req = 8'h08;
      cycle();
      call_req = '0;
      cycle();
      check("retarget_3", int'(target_floor), 3);
      cur_floor = 3'd3; arrive = 1'b1;
      cycle();
      arrive = 1'b0;
      run_cycles(4);
      check("continue_up_dir", int'(dir_up), 1);
      check("continue_up_target", int'(target_floor), 6);
      cur_floor = 3'd6; arrive = 1'b1;
      cycle();
      arrive = 1'b0;
      run_cycles(4);

      // SCAN: going up at floor 4 with calls at 1 and 6
      cur_floor = 3'd4; call_req = 8'h40;
      cycle();
      call_req = 8'h02;
      cycle();
      call_req = '0;
      cycle();
      check("scan_target_6", int'(target_floor), 6);
      cur_floor = 3'd6; arrive = 1'b1;
      cycle();
      arrive = 1'b0;
      for (int k = 0; k < 4; k++) begin
         check("scan_no_dn_in_dwell", int'(dir_dn), 0);
         cycle();
      end
      check("scan_then_dn", int'(dir_dn), 1);
      check("scan_target_1", int'(target_floor), 1);
      run_cycles(3);

      // asynchronous reset while seeking down with pending 8'h81
      do_reset();
      cur_floor = 3'd4; call_req = 8'h01;
      cycle();
      call_req = 8'h80;
      cycle();
      call_req = '0;
      cycle();
      check("pre_reset_dir_dn", int'(dir_dn), 1);
      check("pre_reset_pending", int'(pending), 32'h81);
      #2 rst = 1'b1;
      #1;
      check("async_reset_outputs", int'({pending, target_floor, target_valid, dir_up, dir_dn, door_open}), 0);
      model_reset();
      @(negedge clk);
      rst = 1'b0;
      call_req = 8'h04;
      cycle();
      call_req = '0;
      cycle();
      check("after_reset_dir_dn", int'(dir_dn), 1);
      check("after_reset_target", int'(target_floor), 2);

      // randomized car driven toward the model's target
      for (int n = 0; n < 3000; n++) begin
         call_req  = ($urandom_range(0, 4) == 0) ? FLOORS'(1 << $urandom_range(0, FLOORS - 1)) : '0;
         door_hold = ($urandom_range(0, 9) == 0);
         arrive    = 1'b0;
         if (e_valid && $urandom_range(0, 1) == 0) begin
            if (int'(cur_floor) < e_tgt) cur_floor = cur_floor + 3'd1;
            else if (int'(cur_floor) > e_tgt) cur_floor = cur_floor - 3'd1;
            arrive = (int'(cur_floor) == e_tgt);
         end
         if ($urandom_range(0, 29) == 0) arrive = 1'b1;
         if ($urandom_range(0, 49) == 0) cur_floor = FW'($urandom_range(0, FLOORS - 1));
         cycle();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
